// File: rtl/dmi_bridge.sv
// Single-outstanding DMI sequencer between the debug transport and the Debug Module.
// Define DMI_BRIDGE_TIMEOUT_EN to add the hung-access timeout and late-response discard.
module dmi_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [6:0]  ADDR_LIMIT     = 7'h60
) (
    input  logic        CLK,
    input  logic        RST_N,

    input  logic        up_req_valid_i,
    output logic        up_req_ready_o,
    input  logic [6:0]  up_req_addr_i,
    input  logic [31:0] up_req_data_i,
    input  logic [1:0]  up_req_op_i,

    output logic        up_rsp_valid_o,
    input  logic        up_rsp_ready_i,
    output logic [31:0] up_rsp_data_o,
    output logic [1:0]  up_rsp_response_o,

    output logic        dm_req_valid_o,
    input  logic        dm_req_ready_i,
    output logic [6:0]  dm_req_addr_o,
    output logic [31:0] dm_req_data_o,
    output logic [1:0]  dm_req_op_o,

    input  logic        dm_rsp_valid_i,
    output logic        dm_rsp_ready_o,
    input  logic [31:0] dm_rsp_data_i,
    input  logic [1:0]  dm_rsp_response_i
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    localparam logic [1:0] OP_NOP     = 2'd0;
    localparam logic [1:0] OP_RSVD    = 2'd3;
    localparam logic [1:0] RSP_OK     = 2'd0;
    localparam logic [1:0] RSP_FAILED = 2'd2;

    state_e      state_q;
    logic        up_req_ready_q;
    logic [31:0] up_rsp_data_q;
    logic [1:0]  up_rsp_response_q;
    logic [6:0]  dm_req_addr_q;
    logic [31:0] dm_req_data_q;
    logic [1:0]  dm_req_op_q;

    logic        drop_pending;
    logic        timeout_fire;

`ifdef DMI_BRIDGE_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] cnt_q;
    logic             drop_pending_q;

    // A response arriving on the threshold cycle beats the timeout.
    assign timeout_fire = (state_q == WAIT) && !dm_rsp_valid_i
                          && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign drop_pending = drop_pending_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt_q          <= '0;
            drop_pending_q <= 1'b0;
        end else begin
            if (dm_req_valid_o && dm_req_ready_i) begin
                cnt_q <= '0;
            end else if (state_q == WAIT && cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (timeout_fire) begin
                drop_pending_q <= 1'b1;
            end else if (drop_pending_q && dm_rsp_valid_i) begin
                drop_pending_q <= 1'b0;
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout_fire       = 1'b0;
    assign drop_pending       = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    // NOTE: reset is synchronous and every register, including payloads, is cleared
    // so a transaction cut short by reset leaves nothing visible downstream.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q           <= IDLE;
            up_req_ready_q    <= 1'b0;
            up_rsp_data_q     <= '0;
            up_rsp_response_q <= RSP_OK;
            dm_req_addr_q     <= '0;
            dm_req_data_q     <= '0;
            dm_req_op_q       <= OP_NOP;
        end else begin
            // NOTE: non-blocking assignments throughout; later ones in this block
            // override the defaults above them within the same cycle.
            case (state_q)
                IDLE: begin
                    up_req_ready_q <= 1'b1;
                    if (up_req_valid_i && up_req_ready_q) begin
                        up_req_ready_q <= 1'b0;
                        dm_req_addr_q  <= up_req_addr_i;
                        dm_req_data_q  <= up_req_data_i;
                        dm_req_op_q    <= up_req_op_i;
                        up_rsp_data_q  <= '0;
                        if (up_req_op_i == OP_NOP) begin
                            up_rsp_response_q <= RSP_OK;
                            state_q           <= RESP;
                        end else if (up_req_op_i == OP_RSVD || up_req_addr_i >= ADDR_LIMIT) begin
                            up_rsp_response_q <= RSP_FAILED;
                            state_q           <= RESP;
                        end else begin
                            state_q <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (dm_req_valid_o && dm_req_ready_i) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (dm_rsp_valid_i) begin
                        up_rsp_data_q     <= dm_rsp_data_i;
                        up_rsp_response_q <= dm_rsp_response_i;
                        state_q           <= RESP;
                    end else if (timeout_fire) begin
                        up_rsp_data_q     <= '0;
                        up_rsp_response_q <= RSP_FAILED;
                        state_q           <= RESP;
                    end
                end
                RESP: begin
                    if (up_rsp_ready_i) begin
                        up_req_ready_q <= 1'b1;
                        state_q        <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshake outputs decode from registered state only, never from inputs.
    assign up_req_ready_o    = up_req_ready_q;
    assign up_rsp_valid_o    = (state_q == RESP);
    assign up_rsp_data_o     = up_rsp_data_q;
    assign up_rsp_response_o = up_rsp_response_q;
    assign dm_req_valid_o    = (state_q == ISSUE) && !drop_pending;
    assign dm_req_addr_o     = dm_req_addr_q;
    assign dm_req_data_o     = dm_req_data_q;
    assign dm_req_op_o       = dm_req_op_q;
    assign dm_rsp_ready_o    = (state_q == WAIT) || drop_pending;

endmodule

// File: tb/tb_dmi_bridge.sv
// Scoreboard bench for dmi_bridge: directed requests push expected DM requests and
// upstream responses; negedge monitors pop and compare on every handshake.
`timescale 1ns/1ps
module tb_dmi_bridge;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } up_rsp_t;

    typedef struct packed {
        logic [6:0]  addr;
        logic [31:0] data;
        logic [1:0]  op;
    } dm_req_t;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        up_req_valid;
    logic        up_req_ready;
    logic [6:0]  up_req_addr;
    logic [31:0] up_req_data;
    logic [1:0]  up_req_op;
    logic        up_rsp_valid;
    logic        up_rsp_ready;
    logic [31:0] up_rsp_data;
    logic [1:0]  up_rsp_response;
    logic        dm_req_valid;
    logic        dm_req_ready;
    logic [6:0]  dm_req_addr;
    logic [31:0] dm_req_data;
    logic [1:0]  dm_req_op;
    logic        dm_rsp_valid;
    logic        dm_rsp_ready;
    logic [31:0] dm_rsp_data;
    logic [1:0]  dm_rsp_response;

    up_rsp_t up_exp_q[$];
    dm_req_t dm_exp_q[$];
    int      checks   = 0;
    int      errors   = 0;
    int      dm_xfers = 0;

    always #5 CLK = ~CLK;

    dmi_bridge #(
        .TIMEOUT_CYCLES (16),
        .ADDR_LIMIT     (7'h60)
    ) dut (
        .CLK               (CLK),
        .RST_N             (RST_N),
        .up_req_valid_i    (up_req_valid),
        .up_req_ready_o    (up_req_ready),
        .up_req_addr_i     (up_req_addr),
        .up_req_data_i     (up_req_data),
        .up_req_op_i       (up_req_op),
        .up_rsp_valid_o    (up_rsp_valid),
        .up_rsp_ready_i    (up_rsp_ready),
        .up_rsp_data_o     (up_rsp_data),
        .up_rsp_response_o (up_rsp_response),
        .dm_req_valid_o    (dm_req_valid),
        .dm_req_ready_i    (dm_req_ready),
        .dm_req_addr_o     (dm_req_addr),
        .dm_req_data_o     (dm_req_data),
        .dm_req_op_o       (dm_req_op),
        .dm_rsp_valid_i    (dm_rsp_valid),
        .dm_rsp_ready_o    (dm_rsp_ready),
        .dm_rsp_data_i     (dm_rsp_data),
        .dm_rsp_response_i (dm_rsp_response)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Upstream response monitor.
    always @(negedge CLK) begin : up_mon
        up_rsp_t e;
        if (RST_N === 1'b1 && up_rsp_valid === 1'b1 && up_rsp_ready === 1'b1) begin
            if (up_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL up_rsp_unexpected: got data %h response %0d, expected no response",
                         up_rsp_data, up_rsp_response);
            end else begin
                e = up_exp_q.pop_front();
                check("up_rsp_data", up_rsp_data, e.data);
                check("up_rsp_response", 32'(up_rsp_response), 32'(e.resp));
            end
        end
    end

    // Debug Module request monitor.
    always @(negedge CLK) begin : dm_mon
        dm_req_t e;
        if (RST_N === 1'b1 && dm_req_valid === 1'b1 && dm_req_ready === 1'b1) begin
            dm_xfers++;
            if (dm_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dm_req_unexpected: got addr %h op %0d, expected no request",
                         dm_req_addr, dm_req_op);
            end else begin
                e = dm_exp_q.pop_front();
                check("dm_req_addr", 32'(dm_req_addr), 32'(e.addr));
                check("dm_req_data", dm_req_data, e.data);
                check("dm_req_op", 32'(dm_req_op), 32'(e.op));
            end
        end
    end

    task automatic send_req(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
        check("up_req_ready_before_accept", 32'(up_req_ready), 32'd1);
        up_req_valid = 1'b1;
        up_req_addr  = a;
        up_req_data  = d;
        up_req_op    = op;
        step();
        up_req_valid = 1'b0;
        check("up_req_ready_after_accept", 32'(up_req_ready), 32'd0);
    endtask

    task automatic dm_respond(input logic [31:0] d, input logic [1:0] r);
        dm_rsp_valid    = 1'b1;
        dm_rsp_data     = d;
        dm_rsp_response = r;
        step();
        dm_rsp_valid    = 1'b0;
    endtask

    // Forwarded read with dm_req_ready and up_rsp_ready held high.
    task automatic do_read(input logic [6:0] a, input logic [31:0] rdata,
                           input logic [1:0] rresp, input int lat);
        up_exp_q.push_back(up_rsp_t'{data: rdata, resp: rresp});
        dm_exp_q.push_back(dm_req_t'{addr: a, data: 32'h0, op: 2'd1});
        send_req(a, 32'h0, 2'd1);
        check("dm_req_valid_issue", 32'(dm_req_valid), 32'd1);
        step();
        repeat (lat) step();
        dm_respond(rdata, rresp);
        check("up_rsp_valid_after_capture", 32'(up_rsp_valid), 32'd1);
        step();
        check("up_req_ready_after_rsp", 32'(up_req_ready), 32'd1);
    endtask

    task automatic do_local(input logic [6:0] a, input logic [1:0] op, input logic [1:0] rresp);
        up_exp_q.push_back(up_rsp_t'{data: 32'h0, resp: rresp});
        send_req(a, 32'hFFFF_FFFF, op);
        check("local_up_rsp_valid", 32'(up_rsp_valid), 32'd1);
        check("local_no_dm_req", 32'(dm_req_valid), 32'd0);
        step();
        check("local_up_req_ready", 32'(up_req_ready), 32'd1);
    endtask

    task automatic check_reset_outputs();
        check("rst_up_req_ready", 32'(up_req_ready), 32'd0);
        check("rst_up_rsp_valid", 32'(up_rsp_valid), 32'd0);
        check("rst_dm_req_valid", 32'(dm_req_valid), 32'd0);
        check("rst_dm_rsp_ready", 32'(dm_rsp_ready), 32'd0);
        check("rst_up_rsp_data", up_rsp_data, 32'h0);
        check("rst_up_rsp_response", 32'(up_rsp_response), 32'd0);
        check("rst_dm_req_addr", 32'(dm_req_addr), 32'd0);
        check("rst_dm_req_data", dm_req_data, 32'h0);
        check("rst_dm_req_op", 32'(dm_req_op), 32'd0);
    endtask

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation did not finish within 50000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int base;
        RST_N           = 1'b0;
        up_req_valid    = 1'b0;
        up_req_addr     = '0;
        up_req_data     = '0;
        up_req_op       = '0;
        up_rsp_ready    = 1'b1;
        dm_req_ready    = 1'b1;
        dm_rsp_valid    = 1'b0;
        dm_rsp_data     = '0;
        dm_rsp_response = '0;

        step();
        step();
        check_reset_outputs();
        RST_N = 1'b1;
        step();
        check("up_req_ready_after_reset", 32'(up_req_ready), 32'd1);

        // Read forward: DM answers in the second WAIT cycle.
        up_exp_q.push_back(up_rsp_t'{data: 32'h0000_0382, resp: 2'd0});
        dm_exp_q.push_back(dm_req_t'{addr: 7'h11, data: 32'h0, op: 2'd1});
        send_req(7'h11, 32'h0, 2'd1);
        check("read_dm_req_valid", 32'(dm_req_valid), 32'd1);
        step();
        check("read_dm_rsp_ready_wait", 32'(dm_rsp_ready), 32'd1);
        check("read_no_early_rsp", 32'(up_rsp_valid), 32'd0);
        step();
        dm_respond(32'h0000_0382, 2'd0);
        check("read_up_rsp_valid", 32'(up_rsp_valid), 32'd1);
        step();
        check("read_up_req_ready", 32'(up_req_ready), 32'd1);

        // Write with 3 cycles of DM backpressure.
        base         = dm_xfers;
        dm_req_ready = 1'b0;
        up_exp_q.push_back(up_rsp_t'{data: 32'h0, resp: 2'd0});
        dm_exp_q.push_back(dm_req_t'{addr: 7'h10, data: 32'h8000_0001, op: 2'd2});
        send_req(7'h10, 32'h8000_0001, 2'd2);
        for (int i = 0; i < 3; i++) begin
            check("bp_dm_req_valid", 32'(dm_req_valid), 32'd1);
            check("bp_dm_req_addr", 32'(dm_req_addr), 32'h10);
            check("bp_dm_req_data", dm_req_data, 32'h8000_0001);
            check("bp_dm_req_op", 32'(dm_req_op), 32'd2);
            step();
        end
        dm_req_ready = 1'b1;
        step();
        dm_respond(32'h0, 2'd0);
        check("write_up_rsp_valid", 32'(up_rsp_valid), 32'd1);
        step();
        check("write_single_dm_xfer", 32'(dm_xfers - base), 32'd1);

        // Local completions, including the ADDR_LIMIT boundary.
        do_local(7'h04, 2'd0, 2'd0);
        do_local(7'h04, 2'd3, 2'd2);
        do_local(7'h70, 2'd1, 2'd2);
        do_local(7'h60, 2'd1, 2'd2);

        // Highest legal address; response codes 3 and 1 pass through.
        do_read(7'h5F, 32'hA5A5_5A5A, 2'd3, 0);
        do_read(7'h01, 32'h0000_0001, 2'd1, 2);

        // Upstream response held for 5 cycles.
        up_rsp_ready = 1'b0;
        up_exp_q.push_back(up_rsp_t'{data: 32'hCAFE_0004, resp: 2'd0});
        dm_exp_q.push_back(dm_req_t'{addr: 7'h04, data: 32'h0, op: 2'd1});
        send_req(7'h04, 32'h0, 2'd1);
        step();
        dm_respond(32'hCAFE_0004, 2'd0);
        for (int i = 0; i < 5; i++) begin
            check("hold_up_rsp_valid", 32'(up_rsp_valid), 32'd1);
            check("hold_up_rsp_data", up_rsp_data, 32'hCAFE_0004);
            check("hold_up_rsp_response", 32'(up_rsp_response), 32'd0);
            check("hold_up_req_ready", 32'(up_req_ready), 32'd0);
            step();
        end
        up_rsp_ready = 1'b1;
        check("hold_up_req_ready_hs", 32'(up_req_ready), 32'd0);
        step();
        check("hold_up_req_ready_after", 32'(up_req_ready), 32'd1);

        // Reset while in WAIT: no response, everything back to reset values.
        dm_exp_q.push_back(dm_req_t'{addr: 7'h12, data: 32'h0, op: 2'd1});
        send_req(7'h12, 32'h0, 2'd1);
        step();
        check("rstwait_dm_rsp_ready", 32'(dm_rsp_ready), 32'd1);
        RST_N = 1'b0;
        step();
        check_reset_outputs();
        RST_N = 1'b1;
        step();
        check("rstwait_up_req_ready", 32'(up_req_ready), 32'd1);
        do_read(7'h13, 32'h0000_0013, 2'd0, 0);

`ifdef DMI_BRIDGE_TIMEOUT_EN
        // Silent DM: failed response after the 16th WAIT cycle.
        up_exp_q.push_back(up_rsp_t'{data: 32'h0, resp: 2'd2});
        dm_exp_q.push_back(dm_req_t'{addr: 7'h20, data: 32'h0, op: 2'd1});
        send_req(7'h20, 32'h0, 2'd1);
        step();
        for (int i = 0; i < 16; i++) begin
            check("timeout_not_early", 32'(up_rsp_valid), 32'd0);
            step();
        end
        check("timeout_up_rsp_valid", 32'(up_rsp_valid), 32'd1);
        check("timeout_drop_ready_resp", 32'(dm_rsp_ready), 32'd1);
        step();
        check("timeout_drop_ready_idle", 32'(dm_rsp_ready), 32'd1);

        // Next request is held until the late response is discarded.
        up_exp_q.push_back(up_rsp_t'{data: 32'h0000_0021, resp: 2'd0});
        dm_exp_q.push_back(dm_req_t'{addr: 7'h21, data: 32'h0, op: 2'd1});
        send_req(7'h21, 32'h0, 2'd1);
        check("drop_blocks_dm_req_0", 32'(dm_req_valid), 32'd0);
        step();
        check("drop_blocks_dm_req_1", 32'(dm_req_valid), 32'd0);
        dm_respond(32'h0000_0BAD, 2'd0);
        check("drop_cleared_dm_req", 32'(dm_req_valid), 32'd1);
        check("drop_not_forwarded", 32'(up_rsp_valid), 32'd0);
        step();
        dm_respond(32'h0000_0021, 2'd0);
        check("after_drop_up_rsp_valid", 32'(up_rsp_valid), 32'd1);
        step();

        // Response on the threshold cycle wins over the timeout.
        up_exp_q.push_back(up_rsp_t'{data: 32'h0000_0022, resp: 2'd0});
        dm_exp_q.push_back(dm_req_t'{addr: 7'h22, data: 32'h0, op: 2'd1});
        send_req(7'h22, 32'h0, 2'd1);
        step();
        repeat (15) step();
        dm_respond(32'h0000_0022, 2'd0);
        check("race_up_rsp_valid", 32'(up_rsp_valid), 32'd1);
        step();
        check("race_no_drop", 32'(dm_rsp_ready), 32'd0);
`endif

        step();
        check("up_exp_drained", 32'(up_exp_q.size()), 32'd0);
        check("dm_exp_drained", 32'(dm_exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
